// File: rtl/abc_vector_sequencer_if.sv
// Bus between the vector sequencer and whatever consumes its stimulus/response.
// The sequencer holds the master modport; a bench or host holds the slave modport.
interface abc_vector_sequencer_if #(
  parameter int NUM_STEPS = 9
);
  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int ERR_W = $clog2(NUM_STEPS + 1);

  logic                 start;
  logic                 y;
  logic                 a;
  logic                 b;
  logic                 c;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     step_idx;
  logic                 mismatch;
  logic [NUM_STEPS-1:0] y_log;
  logic [ERR_W-1:0]     err_count;

  modport master (
    input  start, y,
    output a, b, c, busy, done, step_idx, mismatch, y_log, err_count
  );

  modport slave (
    output start, y,
    input  a, b, c, busy, done, step_idx, mismatch, y_log, err_count
  );
endinterface

// File: rtl/abc_vector_sequencer.sv
// Clocked stimulus driver for a 3-input combinational block: walks {A,B,C} through
// a fixed vector table, samples Y at the end of each hold window and scores it.
module abc_vector_sequencer #(
  parameter int                     NUM_STEPS   = 9,
  parameter int                     HOLD_CYCLES = 20,
  parameter logic [3*NUM_STEPS-1:0] VECTORS     = {3'b101, 3'b000, 3'b010, 3'b111, 3'b001,
                                                   3'b011, 3'b000, 3'b100, 3'b000},
  parameter logic [NUM_STEPS-1:0]   EXPECT      = 9'h072,
  parameter int                     ERR_W       = $clog2(NUM_STEPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  abc_vector_sequencer_if.master  bus
);

  localparam int IDX_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [2:0]           abc;
  logic                 busy;
  logic                 done;
  logic                 mismatch;
  logic [IDX_W-1:0]     step_idx;
  logic [HOLD_W-1:0]    hold;
  logic [NUM_STEPS-1:0] y_log;
  logic [ERR_W-1:0]     err_count;

  function automatic logic [2:0] vec_at(input logic [IDX_W-1:0] idx);
    return VECTORS[3*idx +: 3];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      abc       <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      step_idx  <= '0;
      hold      <= '0;
      y_log     <= '0;
      err_count <= '0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          abc  <= 3'b000;
          busy <= 1'b0;
          if (bus.start) begin
            abc       <= vec_at('0);
            busy      <= 1'b1;
            step_idx  <= '0;
            hold      <= '0;
            y_log     <= '0;
            err_count <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (hold == LAST_HOLD) begin
            // End of the hold window: the vector has been stable for HOLD_CYCLES cycles.
            y_log[step_idx] <= bus.y;
            if (bus.y != EXPECT[step_idx]) begin
              err_count <= err_count + ERR_W'(1);
              mismatch  <= 1'b1;
            end
            if (step_idx == LAST_IDX) begin
              abc   <= 3'b000;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step_idx <= step_idx + IDX_W'(1);
              abc      <= vec_at(step_idx + IDX_W'(1));
              hold     <= '0;
            end
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = abc[2];
  assign bus.b         = abc[1];
  assign bus.c         = abc[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mismatch  = mismatch;
  assign bus.step_idx  = step_idx;
  assign bus.y_log     = y_log;
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_abc_vector_sequencer.sv
// Randomized bench for abc_vector_sequencer: a default-timing instance and a
// HOLD_CYCLES=1 instance, each scored against a step-table reference model.
module tb_abc_vector_sequencer;

  localparam int N = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   ymode = 0;
  logic [N-1:0] rnd_y = '0;
  int   sel = 0;
  int   total = 0;
  int   bad = 0;

  logic [2:0] vec_tab [N] = '{3'b000, 3'b100, 3'b000, 3'b011, 3'b001,
                              3'b111, 3'b010, 3'b000, 3'b101};
  logic [N-1:0] exp_mask = 9'h072;

  always #5 clk = ~clk;

  abc_vector_sequencer_if #(.NUM_STEPS(N)) i0 ();
  abc_vector_sequencer_if #(.NUM_STEPS(N)) i1 ();

  abc_vector_sequencer #(.NUM_STEPS(N), .HOLD_CYCLES(20)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (i0.master)
  );

  abc_vector_sequencer #(.NUM_STEPS(N), .HOLD_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.master)
  );

  // Stand-in for the downstream block: parity, stuck-at-0, or a random bit per step.
  function automatic logic y_fn(input int m, input logic [2:0] v, input logic [3:0] s,
                                input logic [N-1:0] r);
    if (m == 0) return ^v;
    if (m == 1) return 1'b0;
    return (s < N) ? r[s] : 1'b0;
  endfunction

  assign i0.start = start0;
  assign i1.start = start1;
  assign i0.y = y_fn(ymode, {i0.a, i0.b, i0.c}, i0.step_idx, rnd_y);
  assign i1.y = y_fn(ymode, {i1.a, i1.b, i1.c}, i1.step_idx, rnd_y);

  logic [2:0]   o_abc;
  logic         o_busy, o_done, o_mm;
  logic [3:0]   o_step;
  logic [N-1:0] o_log;
  logic [3:0]   o_err;

  assign o_abc  = (sel != 0) ? {i1.a, i1.b, i1.c} : {i0.a, i0.b, i0.c};
  assign o_busy = (sel != 0) ? i1.busy : i0.busy;
  assign o_done = (sel != 0) ? i1.done : i0.done;
  assign o_mm   = (sel != 0) ? i1.mismatch : i0.mismatch;
  assign o_step = (sel != 0) ? i1.step_idx : i0.step_idx;
  assign o_log  = (sel != 0) ? i1.y_log : i0.y_log;
  assign o_err  = (sel != 0) ? i1.err_count : i0.err_count;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_abc"}, 32'(o_abc), 0);
    check_val({tag, "_busy"}, 32'(o_busy), 0);
    check_val({tag, "_done"}, 32'(o_done), 0);
    check_val({tag, "_mm"}, 32'(o_mm), 0);
    check_val({tag, "_step"}, 32'(o_step), 0);
    check_val({tag, "_log"}, 32'(o_log), 0);
    check_val({tag, "_err"}, 32'(o_err), 0);
  endtask

  // Full run against the model; noise toggles start randomly while the run is active.
  task automatic run_check(input int which, input int hold, input int mode, input bit noise,
                           output logic [N-1:0] got_log, output int got_err);
    logic [N-1:0] elog;
    int           eerr;
    int           mm_k [$];
    int           s;
    bit           emm;
    logic         ys;
    sel   = which;
    ymode = mode;
    rnd_y = N'($urandom);
    eerr  = 0;
    elog  = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) ys = ^vec_tab[i];
      else if (mode == 1) ys = 1'b0;
      else ys = rnd_y[i];
      elog[i] = ys;
      if (ys != exp_mask[i]) begin
        eerr++;
        mm_k.push_back((i + 1) * hold + 1);
      end
    end
    @(negedge clk);
    set_start(1'b1);
    for (int k = 1; k <= N * hold + 1; k++) begin
      @(negedge clk);
      set_start(noise ? 1'($urandom_range(0, 1)) : 1'b0);
      emm = 1'b0;
      foreach (mm_k[j]) if (mm_k[j] == k) emm = 1'b1;
      check_val("mismatch", 32'(o_mm), 32'(emm));
      if (k == 1) begin
        check_val("clr_log", 32'(o_log), 0);
        check_val("clr_err", 32'(o_err), 0);
      end
      if (k <= N * hold) begin
        s = (k - 1) / hold;
        check_val("abc", 32'(o_abc), 32'(vec_tab[s]));
        check_val("busy", 32'(o_busy), 1);
        check_val("step", 32'(o_step), 32'(s));
        check_val("done_early", 32'(o_done), 0);
      end else begin
        check_val("done", 32'(o_done), 1);
        check_val("busy_done", 32'(o_busy), 0);
        check_val("abc_done", 32'(o_abc), 0);
        check_val("y_log", 32'(o_log), 32'(elog));
        check_val("err_count", 32'(o_err), 32'(eerr));
      end
    end
    @(negedge clk);
    set_start(1'b0);
    check_val("idle_busy", 32'(o_busy), 0);
    check_val("idle_done", 32'(o_done), 0);
    check_val("hold_log", 32'(o_log), 32'(elog));
    check_val("hold_err", 32'(o_err), 32'(eerr));
    got_log = o_log;
    got_err = 32'(o_err);
  endtask

  initial begin
    logic [N-1:0] lg;
    int           er;

    // Reset held with start asserted.
    rst    = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0;
    check_reset_outputs("rst0");
    sel = 1;
    check_reset_outputs("rst1");
    rst    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);

    // Default timing, parity response, no start noise.
    run_check(0, 20, 0, 1'b0, lg, er);
    check_val("xor_log_const", 32'(lg), 32'h072);
    check_val("xor_err_const", 32'(er), 0);

    // Stuck-at-0 response with start noise during RUN and DONE.
    run_check(0, 20, 1, 1'b1, lg, er);
    check_val("zero_log_const", 32'(lg), 0);
    check_val("zero_err_const", 32'(er), 4);

    // Random responses, back-to-back restarts clearing previous results.
    for (int r = 0; r < 3; r++) begin
      run_check(0, 20, $urandom_range(0, 2), 1'b1, lg, er);
    end

    // Abort mid step 4 with a reset.
    sel   = 0;
    ymode = 1;
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 1; k <= 4 * 20 + 5; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    check_val("abort_step", 32'(o_step), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check_val("abort_no_done", 32'(o_done), 0);
    end
    run_check(0, 20, 2, 1'b0, lg, er);

    // Single-cycle hold instance.
    run_check(1, 1, 0, 1'b0, lg, er);
    check_val("h1_log_const", 32'(lg), 32'h072);
    for (int r = 0; r < 4; r++) begin
      run_check(1, 1, $urandom_range(0, 2), 1'b1, lg, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
